// File: rtl/cipher_pkg.sv
// Shared constants, state encoding and key conversion for the Vigenere stream cipher.
package cipher_pkg;

  localparam int unsigned ASCII_LC_A  = 97;
  localparam int unsigned ASCII_LC_Z  = 122;
  localparam int unsigned ASCII_SPACE = 32;
  localparam int unsigned ALPHA_N     = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One output beat: result character plus end-of-message flag.
  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } char_beat_t;

  // Key byte to shift amount; anything outside 'a'..'z' shifts by zero.
  function automatic logic [4:0] key_shift(input logic [7:0] b);
    if (b >= 8'(ASCII_LC_A) && b <= 8'(ASCII_LC_Z)) begin
      return 5'(b - 8'(ASCII_LC_A));
    end
    return 5'd0;
  endfunction

endpackage

// File: rtl/vigenere_stream_cipher_if.sv
// Byte-stream handshake bundle: input channel into the engine, output channel to the sink.
interface vigenere_stream_cipher_if;

  logic [7:0] in_char;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  // Source/sink side (drives input stream, consumes output stream).
  modport master (
    output in_char, in_valid, in_last, out_ready,
    input  in_ready, out_char, out_valid, out_last
  );

  // Engine side.
  modport slave (
    input  in_char, in_valid, in_last, out_ready,
    output in_ready, out_char, out_valid, out_last
  );

endinterface

// File: rtl/mod26_shift.sv
// Modulo-26 letter shift: encrypt adds the key shift, decrypt subtracts it.
module mod26_shift
  import cipher_pkg::*;
(
  input  logic [4:0] p_i,
  input  logic [4:0] k_i,
  input  logic       decrypt_i,
  output logic [4:0] result_o
);

  logic [5:0] sum_raw;
  logic [5:0] sum;
  logic [5:0] diff;

  // Both directions computed in 6 bits; inputs are 0..25 so results stay 0..25.
  always_comb begin
    sum_raw = {1'b0, p_i} + {1'b0, k_i};
    sum     = sum_raw;
    if (sum_raw >= 6'(ALPHA_N)) begin
      sum = sum_raw - 6'(ALPHA_N);
    end
    if (p_i >= k_i) begin
      diff = {1'b0, p_i} - {1'b0, k_i};
    end else begin
      diff = {1'b0, p_i} + 6'(ALPHA_N) - {1'b0, k_i};
    end
    result_o = decrypt_i ? 5'(diff) : 5'(sum);
  end

endmodule

// File: rtl/vigenere_stream_cipher.sv
// Streaming Vigenere encrypt/decrypt engine for lowercase ASCII with a single registered output stage.
module vigenere_stream_cipher
  import cipher_pkg::*;
#(
  parameter int unsigned KEY_MAX_LEN = 6,
  parameter int unsigned KL_W        = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     decrypt,
  input  logic [8*KEY_MAX_LEN-1:0] key,
  input  logic [KL_W-1:0]          key_len,
  vigenere_stream_cipher_if.slave  bus,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         char_count
);

  state_e          state_q;
  state_e          state_d;
  logic [4:0]      shift_q [KEY_MAX_LEN];
  logic [KL_W-1:0] len_q;
  logic [KL_W-1:0] kidx_q;
  logic            dec_q;
  char_beat_t      out_q;
  logic            out_valid_q;
  logic            done_q;
  logic [CNT_W-1:0] cnt_q;

  logic [KL_W-1:0] len_eff;
  logic [KL_W-1:0] kidx_nxt;
  logic            xfer;
  logic            out_acc;
  logic            is_lc;
  logic [4:0]      p;
  logic [4:0]      k;
  logic [4:0]      r;

  assign xfer    = bus.in_valid && bus.in_ready;
  assign out_acc = out_valid_q && bus.out_ready;
  assign is_lc   = (bus.in_char >= 8'(ASCII_LC_A)) && (bus.in_char <= 8'(ASCII_LC_Z));
  assign p       = 5'(bus.in_char - 8'(ASCII_LC_A));
  assign k       = shift_q[kidx_q];

  mod26_shift u_shift (
    .p_i       (p),
    .k_i       (k),
    .decrypt_i (dec_q),
    .result_o  (r)
  );

  // Effective key length: zero behaves as one, oversize clamps to the key bus width.
  always_comb begin
    len_eff = key_len;
    if (key_len == '0) begin
      len_eff = KL_W'(1);
    end else if (key_len > KL_W'(KEY_MAX_LEN)) begin
      len_eff = KL_W'(KEY_MAX_LEN);
    end
  end

  // Key index wraps at the latched length.
  always_comb begin
    kidx_nxt = kidx_q + KL_W'(1);
    if (kidx_q == len_q - KL_W'(1)) begin
      kidx_nxt = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; start restarts the message from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (xfer && bus.in_last) state_d = DRAIN;
      DRAIN:   if (start) state_d = RUN;
               else if (out_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept input only in RUN when the output stage can take it.
  always_comb begin
    bus.in_ready = 1'b0;
    busy         = (state_q != IDLE);
    if (state_q == RUN) begin
      bus.in_ready = !out_valid_q || bus.out_ready;
    end
  end

  // Configuration latch on start.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < KEY_MAX_LEN; i++) begin
        shift_q[i] <= '0;
      end
      len_q <= KL_W'(1);
      dec_q <= 1'b0;
    end else if (start) begin
      for (int unsigned i = 0; i < KEY_MAX_LEN; i++) begin
        shift_q[i] <= key_shift(key[8*i +: 8]);
      end
      len_q <= len_eff;
      dec_q <= decrypt;
    end
  end

  // Output stage, key index and letter counter; start drops any pending byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q.ch    <= 8'(ASCII_SPACE);
      out_q.last  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      kidx_q      <= '0;
    end else if (start) begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      kidx_q      <= '0;
    end else begin
      done_q <= (state_q == DRAIN) && out_acc;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_q.last  <= bus.in_last;
        if (is_lc) begin
          out_q.ch <= 8'(r) + 8'(ASCII_LC_A);
          kidx_q   <= kidx_nxt;
          cnt_q    <= cnt_q + CNT_W'(1);
        end else begin
          out_q.ch <= 8'(ASCII_SPACE);
        end
      end else if (out_acc) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_char  = out_q.ch;
  assign bus.out_last  = out_q.last;
  assign bus.out_valid = out_valid_q;
  assign done          = done_q;
  assign char_count    = cnt_q;

endmodule

// File: doc/vigenere_stream_cipher.md
Name: vigenere_stream_cipher

Overview:
- Streaming Vigenère encrypt/decrypt engine for lowercase ASCII text; the parametrised successor of the single-character Caesar shift.
- Key is a multi-character string of up to KEY_MAX_LEN bytes, latched on start.
- Byte stream in and out over valid/ready handshakes, one registered output stage.
- Sits between the keyboard/character buffer and the display/transmit path.

Parameters:
- KEY_MAX_LEN, 6, maximum key characters; key bus is 8*KEY_MAX_LEN bits and byte 0 is the first key char.
- KL_W, 3, width of key_len; must hold KEY_MAX_LEN.
- CNT_W, 16, width of char_count.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: latch key, key_len and decrypt; begin message
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on start
- key  in  8*KEY_MAX_LEN  ASCII key bytes
- key_len  in  KL_W  number of valid key bytes
- in_char  in  8  ASCII input byte
- in_valid  in  1  in_char valid
- in_last  in  1  qualifies final byte of message
- in_ready  out  1  engine accepts in_char this cycle
- out_char  out  8  ASCII result byte
- out_valid  out  1  out_char valid
- out_last  out  1  out_char is final byte of message
- out_ready  in  1  sink accepts out_char
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the final byte is accepted by the sink
- char_count  out  CNT_W  letters processed since start; wraps at 2^CNT_W

Behaviour:
- Reset: state=IDLE; out_char=8'd32; out_valid=0; out_last=0; done=0; busy=0; char_count=0; key index=0; latched shifts=0. Reset wins over every other input, including mid-message.
- States:
  - IDLE: in_ready=0. start -> latch config, -> RUN.
  - RUN: accepts input. An accepted byte with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0. out_valid&&out_ready -> pulse done, -> IDLE.
- Start in RUN or DRAIN: re-latches config, clears key index, char_count and out_valid (pending byte is discarded), enters RUN. No done pulse.
- Key latch: each key byte is converted to a shift 0..25 ('a'=0). A non-lowercase key byte gives shift 0.
- key_len=0 is treated as 1. key_len>KEY_MAX_LEN is clamped to KEY_MAX_LEN.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - A transfer occurs when in_valid && in_ready.
  - Latency is 1 cycle: the result is registered on the transfer edge, and out_valid rises the next cycle.
  - out_char/out_last are held stable while out_valid && !out_ready.
  - Full throughput: a new byte every cycle while out_ready=1.
- Character rules:
  - Lowercase p ('a'..'z' → 0..25), shift k at key index.
  - Encrypt: s=p+k; if s>=26 then s-26.
  - Decrypt: if p>=k then p-k else p+26-k.
  - out = result+97. Key index advances and char_count increments.
  - Any other byte, including 32 and uppercase: out=8'd32. Key index and char_count are unchanged.
- Key index: wraps from latched_len-1 to 0. If latched_len=1 it stays 0, which is plain Caesar.
- Internal arithmetic is 6-bit unsigned; no value outside 0..25 reaches the +97 stage.
- out_last = in_last of the accepted byte.

Decomposition:
- Shared package cipher_pkg holds:
  - ASCII_LC_A=97, ASCII_LC_Z=122, ASCII_SPACE=32, ALPHA_N=26.
  - State encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- One natural sub-module, mod26_shift: combinational (p, k, decrypt) -> result, 5-bit in/out. It is instantiated once on the datapath and reused in the test bench as the reference model.

Test Plan:
- Encrypt: key "lemon", len 5; stream "attackatdawn", in_last on 'n', out_ready=1 -> out "lxfopvefrnhr", 12 consecutive cycles; done 1 cycle after the last transfer; char_count=12.
- Decrypt: same key, decrypt=1, input "lxfopvefrnhr" -> "attackatdawn".
- Non-letters: key "lemon", input "at tack!" -> "lx fopv " (spaces and '!' → 32, key index not advanced); char_count=6.
- Caesar and key edges:
  - key "d", len 1, input "xyz" -> "abc".
  - key_len=0 with key "d" -> same result.
  - key "aBc", len 3 -> shifts 0,0,2.
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 -> out_char stable, in_ready=0, no input consumed; then out_ready=1 -> stream resumes with no byte lost or duplicated.
- Interrupt and reset:
  - start pulse mid-"attack" -> pending byte dropped, key index restarts at 0.
  - Separately, reset asserted in DRAIN -> next cycle busy=0, out_valid=0, out_char=32, char_count=0, no done.
